// File: rtl/slavefifo2b_pkg.sv
// Shared encodings for the slave-FIFO pin output stage: mode codes, FSM states, fixed pin levels.
package slavefifo2b_pkg;

    localparam logic [1:0] MODE_NONE    = 2'd0;
    localparam logic [1:0] MODE_STREAM  = 2'd1;
    localparam logic [1:0] MODE_PARTIAL = 2'd2;
    localparam logic [1:0] MODE_ZLP     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    // Write-only thread on socket 0.
    localparam logic       SLCS_VAL  = 1'b0;
    localparam logic       SLRD_VAL  = 1'b1;
    localparam logic       SLOE_VAL  = 1'b1;
    localparam logic [1:0] FADDR_VAL = 2'b00;

    // {zlp, partial, stream} select vector for a mode code.
    function automatic logic [2:0] mode_onehot(input logic [1:0] m);
        logic [2:0] oh;
        oh = 3'b000;
        case (m)
            MODE_STREAM:  oh = 3'b001;
            MODE_PARTIAL: oh = 3'b010;
            MODE_ZLP:     oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/slavefifo2b_flag_sync.sv
// Two-flop synchroniser for one raw FX3 flag.
module slavefifo2b_flag_sync (
    input  logic clk_100,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/slavefifo2b_bus_if.sv
// FX3 slave-FIFO pin stage: flag sync, mode arbitration with drain/turnaround, registered pin mux, stats.
// Optional sticky protocol checker enabled by defining SLAVEFIFO_PROTO_CHK_EN.
module slavefifo2b_bus_if
    import slavefifo2b_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 32
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic [1:0]        mode_req,
    input  logic              flaga,
    input  logic              flagb,
    output logic              flaga_d,
    output logic              flagb_d,
    output logic              stream_mode_selected,
    output logic              partial_mode_selected,
    output logic              zlp_mode_selected,
    input  logic              slwr_stream_,
    input  logic              pktend_stream_,
    input  logic              slwr_partial_,
    input  logic              pktend_partial_,
    input  logic              slwr_zlp_,
    input  logic              pktend_zlp_,
    input  logic [DATA_W-1:0] data_out_stream,
    input  logic [DATA_W-1:0] data_out_partial,
    input  logic [DATA_W-1:0] data_out_zlp,
    output logic              slcs_,
    output logic              slrd_,
    output logic              sloe_,
    output logic [1:0]        faddr,
    output logic              slwr_,
    output logic              pktend_,
    output logic [DATA_W-1:0] fdata,
    output logic              fdata_oe,
    output logic [1:0]        mode_active,
    output logic [CNT_W-1:0]  wr_word_cnt,
    output logic [15:0]       pkt_cnt,
    input  logic              stats_clr,
    output logic              proto_err
);
    localparam int              DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYC - 1);

    state_t            state, state_nxt;
    logic [1:0]        mode_nxt;
    logic [DW-1:0]     drain_cnt, drain_nxt;
    logic [2:0]        sel_q, sel_nxt;
    logic              src_idle;
    logic              mux_slwr, mux_pkt;
    logic [DATA_W-1:0] mux_data;

    slavefifo2b_flag_sync u_sync_a (.clk_100(clk_100), .reset(reset), .d(flaga), .q(flaga_d));
    slavefifo2b_flag_sync u_sync_b (.clk_100(clk_100), .reset(reset), .d(flagb), .q(flagb_d));

    assign slcs_ = SLCS_VAL;
    assign slrd_ = SLRD_VAL;
    assign sloe_ = SLOE_VAL;
    assign faddr = FADDR_VAL;

    assign src_idle = slwr_stream_ & pktend_stream_ & slwr_partial_ &
                      pktend_partial_ & slwr_zlp_ & pktend_zlp_;

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_active;
        drain_nxt = drain_cnt;
        case (state)
            ST_IDLE:
                if (mode_req != MODE_NONE) begin
                    state_nxt = ST_ACTIVE;
                    mode_nxt  = mode_req;
                end
            ST_ACTIVE:
                if (mode_req != mode_active) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end
            ST_DRAIN:
                if (!src_idle)
                    drain_nxt = '0;
                else if (drain_cnt == DRAIN_LAST)
                    state_nxt = ST_TURN;
                else
                    drain_nxt = drain_cnt + 1'b1;
            ST_TURN: begin
                // Whatever is requested now wins, regardless of earlier changes.
                state_nxt = (mode_req != MODE_NONE) ? ST_ACTIVE : ST_IDLE;
                mode_nxt  = mode_req;
            end
            default: begin
                state_nxt = ST_IDLE;
                mode_nxt  = MODE_NONE;
            end
        endcase
    end

    // Select lags the grant by one cycle and drops the moment a change is seen.
    assign sel_nxt = (state == ST_ACTIVE && mode_req == mode_active) ? mode_onehot(mode_active) : 3'b000;

    always_comb begin
        mux_slwr = 1'b1;
        mux_pkt  = 1'b1;
        mux_data = '0;
        if (state == ST_ACTIVE || state == ST_DRAIN) begin
            case (mode_active)
                MODE_STREAM:  begin mux_slwr = slwr_stream_;  mux_pkt = pktend_stream_;  mux_data = data_out_stream;  end
                MODE_PARTIAL: begin mux_slwr = slwr_partial_; mux_pkt = pktend_partial_; mux_data = data_out_partial; end
                MODE_ZLP:     begin mux_slwr = slwr_zlp_;     mux_pkt = pktend_zlp_;     mux_data = data_out_zlp;     end
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_active <= MODE_NONE;
            drain_cnt   <= '0;
            sel_q       <= 3'b000;
            slwr_       <= 1'b1;
            pktend_     <= 1'b1;
            fdata       <= '0;
            wr_word_cnt <= '0;
            pkt_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            mode_active <= mode_nxt;
            drain_cnt   <= drain_nxt;
            sel_q       <= sel_nxt;
            slwr_       <= mux_slwr;
            pktend_     <= mux_pkt;
            fdata       <= mux_data;
            if (stats_clr) begin
                wr_word_cnt <= '0;
                pkt_cnt     <= '0;
            end else begin
                if (!slwr_ && wr_word_cnt != '1)
                    wr_word_cnt <= wr_word_cnt + 1'b1;
                if (!pktend_ && pkt_cnt != '1)
                    pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    assign stream_mode_selected  = sel_q[0];
    assign partial_mode_selected = sel_q[1];
    assign zlp_mode_selected     = sel_q[2];
    assign fdata_oe              = (state == ST_ACTIVE) || (state == ST_DRAIN);

`ifdef SLAVEFIFO_PROTO_CHK_EN
    logic proto_q;
    logic multi_sel;

    assign multi_sel = (sel_nxt & (sel_nxt - 3'd1)) != 3'd0;

    always_ff @(posedge clk_100) begin
        if (reset)
            proto_q <= 1'b0;
        else if ((!slwr_ && !flaga_d) || multi_sel)
            proto_q <= 1'b1;
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_slavefifo2b_bus_if.sv
// Self-checking bench for slavefifo2b_bus_if: table-driven mux vectors plus pin scoreboard and corner sequences.
module tb_slavefifo2b_bus_if;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    logic              clk_100 = 1'b0;
    logic              reset;
    logic [1:0]        mode_req;
    logic              flaga, flagb, flaga_d, flagb_d;
    logic              stream_mode_selected, partial_mode_selected, zlp_mode_selected;
    logic              slwr_stream_, pktend_stream_, slwr_partial_, pktend_partial_, slwr_zlp_, pktend_zlp_;
    logic [DATA_W-1:0] data_out_stream, data_out_partial, data_out_zlp;
    logic              slcs_, slrd_, sloe_;
    logic [1:0]        faddr;
    logic              slwr_, pktend_, fdata_oe;
    logic [DATA_W-1:0] fdata;
    logic [1:0]        mode_active;
    logic [CNT_W-1:0]  wr_word_cnt;
    logic [15:0]       pkt_cnt;
    logic              stats_clr, proto_err;

    slavefifo2b_bus_if #(.DATA_W(DATA_W), .DRAIN_CYC(4), .CNT_W(CNT_W)) dut (
        .clk_100(clk_100), .reset(reset), .mode_req(mode_req),
        .flaga(flaga), .flagb(flagb), .flaga_d(flaga_d), .flagb_d(flagb_d),
        .stream_mode_selected(stream_mode_selected), .partial_mode_selected(partial_mode_selected),
        .zlp_mode_selected(zlp_mode_selected),
        .slwr_stream_(slwr_stream_), .pktend_stream_(pktend_stream_),
        .slwr_partial_(slwr_partial_), .pktend_partial_(pktend_partial_),
        .slwr_zlp_(slwr_zlp_), .pktend_zlp_(pktend_zlp_),
        .data_out_stream(data_out_stream), .data_out_partial(data_out_partial), .data_out_zlp(data_out_zlp),
        .slcs_(slcs_), .slrd_(slrd_), .sloe_(sloe_), .faddr(faddr),
        .slwr_(slwr_), .pktend_(pktend_), .fdata(fdata), .fdata_oe(fdata_oe),
        .mode_active(mode_active), .wr_word_cnt(wr_word_cnt), .pkt_cnt(pkt_cnt),
        .stats_clr(stats_clr), .proto_err(proto_err)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct packed { logic slwr; logic pkt; logic [DATA_W-1:0] data; } pin_t;
    typedef struct { logic [1:0] src; logic slwr; logic pkt; logic [DATA_W-1:0] data; pin_t exp; } vec_t;

    pin_t sb[$];
    vec_t tbl[6];
    int   checks = 0;
    int   errors = 0;
    logic exp_proto;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        slwr_stream_ = 1'b1;  pktend_stream_ = 1'b1;  data_out_stream = '0;
        slwr_partial_ = 1'b1; pktend_partial_ = 1'b1; data_out_partial = '0;
        slwr_zlp_ = 1'b1;     pktend_zlp_ = 1'b1;     data_out_zlp = '0;
    endtask

    task automatic drive_src(input logic [1:0] src, input logic w, input logic p, input logic [DATA_W-1:0] d);
        idle_all();
        case (src)
            2'd1: begin slwr_stream_ = w;  pktend_stream_ = p;  data_out_stream = d;  end
            2'd2: begin slwr_partial_ = w; pktend_partial_ = p; data_out_partial = d; end
            2'd3: begin slwr_zlp_ = w;     pktend_zlp_ = p;     data_out_zlp = d;     end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk_100);
        #1;
    endtask

    // Expected pin values are queued with the stimulus and retired one edge later.
    task automatic cyc(input pin_t e);
        pin_t x;
        sb.push_back(e);
        step();
        x = sb.pop_front();
        chk("slwr_", 32'(slwr_), 32'(x.slwr));
        chk("pktend_", 32'(pktend_), 32'(x.pkt));
        chk("fdata", fdata, x.data);
    endtask

    localparam pin_t IDLE_PIN = '{slwr: 1'b1, pkt: 1'b1, data: '0};

    initial begin
        tbl[0] = '{src: 2'd2, slwr: 1'b0, pkt: 1'b1, data: 32'h0000_00A5, exp: '{1'b0, 1'b1, 32'h0000_00A5}};
        tbl[1] = '{src: 2'd1, slwr: 1'b0, pkt: 1'b1, data: 32'h0000_0011, exp: '{1'b1, 1'b1, 32'h0}};
        tbl[2] = '{src: 2'd3, slwr: 1'b1, pkt: 1'b0, data: 32'h0000_0033, exp: '{1'b1, 1'b1, 32'h0}};
        tbl[3] = '{src: 2'd2, slwr: 1'b1, pkt: 1'b0, data: 32'h0,         exp: '{1'b1, 1'b0, 32'h0}};
        tbl[4] = '{src: 2'd2, slwr: 1'b0, pkt: 1'b0, data: 32'hDEAD_0077, exp: '{1'b0, 1'b0, 32'hDEAD_0077}};
        tbl[5] = '{src: 2'd1, slwr: 1'b0, pkt: 1'b0, data: 32'h0000_0022, exp: '{1'b1, 1'b1, 32'h0}};
`ifdef SLAVEFIFO_PROTO_CHK_EN
        exp_proto = 1'b1;
`else
        exp_proto = 1'b0;
`endif

        reset = 1'b1; mode_req = 2'd0; flaga = 1'b1; flagb = 1'b1; stats_clr = 1'b0;
        idle_all();
        repeat (3) step();
        chk("rst slwr_", 32'(slwr_), 1);
        chk("rst pktend_", 32'(pktend_), 1);
        chk("rst fdata", fdata, 0);
        chk("rst fdata_oe", 32'(fdata_oe), 0);
        chk("rst selects", {29'd0, zlp_mode_selected, partial_mode_selected, stream_mode_selected}, 0);
        chk("rst mode_active", 32'(mode_active), 0);
        chk("rst wr_word_cnt", 32'(wr_word_cnt), 0);
        chk("rst pkt_cnt", 32'(pkt_cnt), 0);
        chk("rst flag syncs", {30'd0, flaga_d, flagb_d}, 0);
        chk("rst proto_err", 32'(proto_err), 0);
        chk("fixed pins", {27'd0, slcs_, slrd_, sloe_, faddr}, 32'b01100);

        reset = 1'b0; mode_req = 2'd2;
        step();
        chk("grant mode_active", 32'(mode_active), 2);
        chk("grant sel early", 32'(partial_mode_selected), 0);
        chk("grant fdata_oe", 32'(fdata_oe), 1);
        step();
        chk("partial sel", 32'(partial_mode_selected), 1);
        chk("stream sel", 32'(stream_mode_selected), 0);
        chk("flaga_d", 32'(flaga_d), 1);
        flagb = 1'b0;
        step();
        chk("flagb_d lag1", 32'(flagb_d), 1);
        step();
        chk("flagb_d lag2", 32'(flagb_d), 0);
        flagb = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive_src(2'd2, 1'b0, 1'b1, DATA_W'(i));
            cyc('{1'b0, 1'b1, DATA_W'(i)});
        end
        idle_all();
        cyc(IDLE_PIN);
        chk("wr_word_cnt 16", 32'(wr_word_cnt), 16);
        chk("pkt_cnt 0", 32'(pkt_cnt), 0);

        for (int i = 0; i < 6; i++) begin
            drive_src(tbl[i].src, tbl[i].slwr, tbl[i].pkt, tbl[i].data);
            cyc(tbl[i].exp);
        end
        idle_all();
        cyc(IDLE_PIN);
        chk("wr_word_cnt table", 32'(wr_word_cnt), 18);
        chk("pkt_cnt table", 32'(pkt_cnt), 2);

        // Mode change while the partial source is mid-burst.
        mode_req = 2'd1;
        drive_src(2'd2, 1'b0, 1'b1, 32'h100);
        cyc('{1'b0, 1'b1, 32'h100});
        chk("drain sel partial", 32'(partial_mode_selected), 0);
        chk("drain sel stream", 32'(stream_mode_selected), 0);
        chk("drain mode_active", 32'(mode_active), 2);
        for (int k = 1; k < 3; k++) begin
            drive_src(2'd2, 1'b0, 1'b1, DATA_W'(32'h100 + k));
            cyc('{1'b0, 1'b1, DATA_W'(32'h100 + k)});
        end
        idle_all();
        for (int k = 0; k < 3; k++) cyc(IDLE_PIN);
        chk("drain oe held", 32'(fdata_oe), 1);
        cyc(IDLE_PIN);
        chk("turn fdata_oe", 32'(fdata_oe), 0);
        chk("turn stream sel", 32'(stream_mode_selected), 0);
        cyc(IDLE_PIN);
        chk("new mode_active", 32'(mode_active), 1);
        chk("new sel early", 32'(stream_mode_selected), 0);
        cyc(IDLE_PIN);
        chk("stream sel", 32'(stream_mode_selected), 1);
        chk("wr_word_cnt drain", 32'(wr_word_cnt), 21);

        for (int i = 0; i < 15; i++) begin
            drive_src(2'd1, 1'b0, 1'b1, DATA_W'(32'h200 + i));
            cyc('{1'b0, 1'b1, DATA_W'(32'h200 + i)});
        end
        idle_all();
        cyc(IDLE_PIN);
        chk("wr_word_cnt sat", 32'(wr_word_cnt), 31);

        drive_src(2'd1, 1'b0, 1'b1, 32'h300);
        cyc('{1'b0, 1'b1, 32'h300});
        drive_src(2'd1, 1'b0, 1'b1, 32'h301);
        stats_clr = 1'b1;
        cyc('{1'b0, 1'b1, 32'h301});
        stats_clr = 1'b0;
        chk("clr wins wr", 32'(wr_word_cnt), 0);
        chk("clr wins pkt", 32'(pkt_cnt), 0);
        idle_all();
        cyc(IDLE_PIN);
        chk("post clr wr", 32'(wr_word_cnt), 1);

        drive_src(2'd1, 1'b0, 1'b0, 32'h400);
        cyc('{1'b0, 1'b0, 32'h400});
        reset = 1'b1;
        step();
        chk("midrst slwr_", 32'(slwr_), 1);
        chk("midrst pktend_", 32'(pktend_), 1);
        chk("midrst fdata_oe", 32'(fdata_oe), 0);
        chk("midrst sel", 32'(stream_mode_selected), 0);
        chk("midrst mode_active", 32'(mode_active), 0);

        idle_all();
        reset = 1'b0; mode_req = 2'd1; flaga = 1'b0;
        repeat (3) step();
        chk("proto quiet", 32'(proto_err), 0);
        drive_src(2'd1, 1'b0, 1'b1, 32'h500);
        cyc('{1'b0, 1'b1, 32'h500});
        idle_all();
        cyc(IDLE_PIN);
        chk("proto set", 32'(proto_err), 32'(exp_proto));
        flaga = 1'b1;
        repeat (3) cyc(IDLE_PIN);
        chk("proto sticky", 32'(proto_err), 32'(exp_proto));
        reset = 1'b1;
        step();
        chk("proto rst", 32'(proto_err), 0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
